// File: rtl/lorenz_step_sequencer.sv
// lorenz_step_sequencer
//   Avalon-MM controlled sequencer for a Lorenz-attractor solver. The host
//   writes shadow copies of sigma/beta/rho, which reach the solver only
//   through a COMMIT (APPLY state) or an INIT (solver reset). With RUN set,
//   the sequencer waits DIV+1 cycles, then issues a one-cycle step_en and
//   holds until the solver answers with step_done.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   address, chipselect,  Avalon-MM slave: 3-bit word address, select,
//   write_n, writedata    active-low write strobe, write data
//   readdata              combinational read mux
//   sigma_out, beta_out,  active parameters driven to the solver
//   rho_out
//   solver_rst            active-high solver state reset
//   step_en               one-cycle step request
//   step_done             solver step-complete pulse
//
// Register map
//   0 sigma shadow   1 beta shadow   2 rho shadow
//   3 CTRL  bit0 RUN (level), bit1 COMMIT (write-1), bit2 INIT (write-1)
//   4 DIV   [DIV_W-1:0]
//   5 STATUS (ro) bit0 busy, bit1 commit_pending, bit2 init_pending,
//                 bits[5:3] state
//   6 step count (ro)
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | arbitrate: INIT pending, then COMMIT pending, then RUN
// INIT   | solver_rst held RST_CYC cycles, params loaded, count cleared
// WAIT   | divider counts 0..DIV before the next step
// STEP   | step_en pulsed on entry, hold until step_done
// APPLY  | one cycle, shadow -> active, commit request retired

module lorenz_step_sequencer #(
    parameter int DIV_W   = 16,
    parameter int RST_CYC = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] sigma_out,
    output logic [31:0] beta_out,
    output logic [31:0] rho_out,
    output logic        solver_rst,
    output logic        step_en,
    input  logic        step_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_STEP  = 3'd3;
    localparam logic [2:0] S_APPLY = 3'd4;

    localparam int              RC_W    = (RST_CYC < 2) ? 1 : $clog2(RST_CYC);
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYC - 1);

    logic [31:0]      sigma_sh, beta_sh, rho_sh;
    logic             run;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_cnt;
    logic [RC_W-1:0]  rst_cnt;
    logic [31:0]      step_cnt;
    logic             commit_pend, init_pend;
    logic             turnaround;
    logic [2:0]       state, state_nxt;

    logic wr_en, wr_ctrl;
    logic init_take, load_active, step_fin;
    logic commit_set, init_set, commit_clr, init_clr;

    assign wr_en   = chipselect & ~write_n;
    assign wr_ctrl = wr_en && (address == 3'd3);

    assign init_take   = (state == S_IDLE) && init_pend;
    assign load_active = init_take || (state == S_APPLY);
    assign step_fin    = (state == S_STEP) && step_done;

    assign commit_set = wr_ctrl && writedata[1];
    assign init_set   = wr_ctrl && writedata[2];
    // INIT loads the active set itself, so it retires a pending COMMIT too.
    assign commit_clr = init_take || (state == S_APPLY);
    assign init_clr   = init_take;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (init_pend)
                    state_nxt = S_INIT;
                else if (commit_pend)
                    state_nxt = S_APPLY;
                else if (run && !turnaround)
                    state_nxt = S_WAIT;
            end
            S_INIT: begin
                if (rst_cnt == '0)
                    state_nxt = S_IDLE;
            end
            S_WAIT: begin
                if (!run || init_pend || commit_pend)
                    state_nxt = S_IDLE;
                else if (div_cnt == div)
                    state_nxt = S_STEP;
            end
            S_STEP: begin
                if (step_done)
                    state_nxt = S_IDLE;
            end
            S_APPLY: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sigma_sh <= '0;
            beta_sh  <= '0;
            rho_sh   <= '0;
            run      <= 1'b0;
            div      <= '0;
        end else if (wr_en) begin
            case (address)
                3'd0: sigma_sh <= writedata;
                3'd1: beta_sh  <= writedata;
                3'd2: rho_sh   <= writedata;
                3'd3: run      <= writedata[0];
                3'd4: div      <= writedata[DIV_W-1:0];
                default: ;
            endcase
        end
    end

    // A request written in the same cycle its service retires it wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_pend <= 1'b0;
            init_pend   <= 1'b0;
        end else begin
            commit_pend <= (commit_pend & ~commit_clr) | commit_set;
            init_pend   <= (init_pend & ~init_clr) | init_set;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sigma_out <= '0;
            beta_out  <= '0;
            rho_out   <= '0;
        end else if (load_active) begin
            sigma_out <= sigma_sh;
            beta_out  <= beta_sh;
            rho_out   <= rho_sh;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            rst_cnt    <= '0;
            step_cnt   <= '0;
            turnaround <= 1'b0;
            solver_rst <= 1'b1;
            step_en    <= 1'b0;
        end else begin
            state      <= state_nxt;
            solver_rst <= (state_nxt == S_INIT);
            step_en    <= (state == S_WAIT) && (state_nxt == S_STEP);

            if ((state == S_WAIT) && (state_nxt == S_WAIT))
                div_cnt <= div_cnt + 1'b1;
            else
                div_cnt <= '0;

            if (init_take)
                rst_cnt <= RC_LOAD;
            else if ((state == S_INIT) && (rst_cnt != '0))
                rst_cnt <= rst_cnt - 1'b1;

            if (init_take)
                step_cnt <= '0;
            else if (step_fin)
                step_cnt <= step_cnt + 32'd1;

            // One extra idle cycle after each completed step before the
            // divider re-arms, so back-to-back steps never abut step_done.
            if (step_fin)
                turnaround <= 1'b1;
            else if (state == S_IDLE)
                turnaround <= 1'b0;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata = sigma_sh;
            3'd1: readdata = beta_sh;
            3'd2: readdata = rho_sh;
            3'd3: readdata[0] = run;
            3'd4: readdata[DIV_W-1:0] = div;
            3'd5: readdata[5:0] = {state, init_pend, commit_pend, (state != S_IDLE)};
            3'd6: readdata = step_cnt;
            default: readdata = '0;
        endcase
    end

endmodule
